// File: rtl/diff_acc4.sv
// diff_acc4: signed running-sum stage for a 4-bit two's complement difference
// stream. Words land in a small FIFO, are popped one per cycle into a
// saturating accumulator, and every new total is offered on O/O_VALID.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. I_READY is decoded from registered state only, and O/O_VALID
// hold steady while O_VALID && !O_READY.
module diff_acc4 #(
    parameter int ACC_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CLR,
    input  logic [3:0]       I,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [ACC_W-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             SAT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W - 1){1'b0}}};

    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             sat_q, sat_d;

    logic             push;
    logic             pop;
    logic [3:0]       entry;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             clip;
    logic [ACC_W-1:0] acc_new;

    // A full FIFO refuses input even when a pop is happening: no bypass.
    assign I_READY = (cnt_q < CNT_FULL);
    assign O       = o_q;
    assign O_VALID = o_valid_q;
    assign SAT     = sat_q;

    // Transfer qualifiers: pop whenever the output register is free or being drained.
    always_comb begin
        push = I_VALID && I_READY;
        pop  = (cnt_q != '0) && (!o_valid_q || O_READY);
    end

    // FIFO storage, pointers (wrap naturally) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = I;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Saturating add one bit wider than the accumulator; CLR zeroes the base
    // of a coincident pop, and a clipping pop sets SAT even when CLR clears it.
    always_comb begin
        entry   = mem_q[rd_ptr_q];
        base    = CLR ? '0 : acc_q;
        sum     = {base[ACC_W-1], base} + {{(ACC_W - 3){entry[3]}}, entry};
        clip    = (sum[ACC_W] != sum[ACC_W-1]);
        acc_new = clip ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

        acc_d     = acc_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        sat_d     = sat_q;
        if (CLR) begin
            acc_d = '0;
            sat_d = 1'b0;
        end
        if (pop) begin
            acc_d     = acc_new;
            o_d       = acc_new;
            o_valid_d = 1'b1;
            if (clip) begin
                sat_d = 1'b1;
            end
        end else if (o_valid_q && O_READY) begin
            o_valid_d = 1'b0;
        end
    end

    // State registers; reset empties the FIFO and discards buffered words.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_diff_acc4.sv
// Directed bench for diff_acc4 (ACC_W=8, DEPTH=2) with hand-computed results.
module tb_diff_acc4;

    logic       CLK;
    logic       RESETN;
    logic       CLR;
    logic [3:0] I;
    logic       I_VALID;
    logic       I_READY;
    logic [7:0] O;
    logic       O_VALID;
    logic       O_READY;
    logic       SAT;

    int n_vec;
    int n_bad;

    diff_acc4 #(.ACC_W(8), .DEPTH(2)) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .CLR     (CLR),
        .I       (I),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .O       (O),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .SAT     (SAT)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated word: push, pop on the next edge, then check the result.
    task automatic send_chk(input logic [3:0] w, input logic [7:0] exp_o,
                            input logic exp_sat, input string tag);
        I       = w;
        I_VALID = 1'b1;
        tick();
        I_VALID = 1'b0;
        tick();
        chk({tag, "_o"},   32'(O),       32'(exp_o));
        chk({tag, "_ov"},  32'(O_VALID), 32'd1);
        chk({tag, "_sat"}, 32'(SAT),     32'(exp_sat));
    endtask

    initial begin
        int e;
        n_vec   = 0;
        n_bad   = 0;
        RESETN  = 1'b0;
        CLR     = 1'b0;
        I       = 4'h0;
        I_VALID = 1'b0;
        O_READY = 1'b1;
        tick();
        tick();
        chk("rst_o",   32'(O),       32'h0);
        chk("rst_ov",  32'(O_VALID), 32'd0);
        chk("rst_sat", 32'(SAT),     32'd0);
        chk("rst_ir",  32'(I_READY), 32'd1);
        RESETN = 1'b1;

        // Basic streaming sequence, one cycle latency
        I = 4'h3; I_VALID = 1'b1; tick();
        chk("bas_ov0", 32'(O_VALID), 32'd0);
        I = 4'hE; tick();
        chk("bas_o1", 32'(O), 32'h03);
        chk("bas_ov1", 32'(O_VALID), 32'd1);
        I = 4'h8; tick();
        chk("bas_o2", 32'(O), 32'h01);
        chk("bas_ir", 32'(I_READY), 32'd1);
        I = 4'h7; tick();
        chk("bas_o3", 32'(O), 32'hF9);
        I_VALID = 1'b0; tick();
        chk("bas_o4", 32'(O), 32'h00);
        chk("bas_ov4", 32'(O_VALID), 32'd1);
        tick();
        chk("bas_ovd", 32'(O_VALID), 32'd0);
        chk("bas_oh", 32'(O), 32'h00);

        // Positive saturation: 7*19 = 133 clips to 127
        for (int n = 1; n <= 20; n++) begin
            e = (7 * n > 127) ? 127 : 7 * n;
            send_chk(4'h7, 8'(e), (n >= 19), "pos");
        end

        // Reset mid-stream with two words buffered behind a stalled output
        O_READY = 1'b0;
        I = 4'h1; I_VALID = 1'b1; tick(); tick();
        chk("mid_ir", 32'(I_READY), 32'd0);
        chk("mid_o",  32'(O),       32'h7F);
        I_VALID = 1'b0;
        #2;
        RESETN = 1'b0;
        #1;
        chk("mid_rst_o",   32'(O),       32'h0);
        chk("mid_rst_ov",  32'(O_VALID), 32'd0);
        chk("mid_rst_sat", 32'(SAT),     32'd0);
        chk("mid_rst_ir",  32'(I_READY), 32'd1);
        tick();
        RESETN  = 1'b1;
        O_READY = 1'b1;
        send_chk(4'h3, 8'h03, 1'b0, "post_rst");

        // CLR without a pop: acc and SAT clear, O holds
        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("clr_o",   32'(O),       32'h03);
        chk("clr_ov",  32'(O_VALID), 32'd0);
        chk("clr_sat", 32'(SAT),     32'd0);

        // Negative saturation: -8*17 = -136 clips to -128
        for (int n = 1; n <= 17; n++) begin
            e = (-8 * n < -128) ? -128 : -8 * n;
            send_chk(4'h8, 8'(e), (n >= 17), "neg");
        end
        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("nclr_sat", 32'(SAT), 32'd0);
        chk("nclr_o",   32'(O),   32'h80);
        send_chk(4'h2, 8'h02, 1'b0, "nclr_next");

        // Backpressure: acc=2, words 1,2,3,4 -> 3,5,8,12
        tick();
        O_READY = 1'b0;
        I = 4'h1; I_VALID = 1'b1; tick();
        I = 4'h2; tick();
        chk("bp_o1", 32'(O), 32'h03);
        I = 4'h3; tick();
        chk("bp_full_ir", 32'(I_READY), 32'd0);
        I = 4'h4; tick();
        chk("bp_hold_o",  32'(O),       32'h03);
        chk("bp_hold_ov", 32'(O_VALID), 32'd1);
        chk("bp_hold_ir", 32'(I_READY), 32'd0);
        tick();
        chk("bp_hold2_o", 32'(O), 32'h03);
        O_READY = 1'b1; tick();
        chk("bp_o2", 32'(O), 32'h05);
        chk("bp_ir_up", 32'(I_READY), 32'd1);
        tick();
        chk("bp_o3", 32'(O), 32'h08);
        I_VALID = 1'b0; tick();
        chk("bp_o4", 32'(O), 32'h0C);
        chk("bp_ov4", 32'(O_VALID), 32'd1);
        tick();
        chk("bp_drained", 32'(O_VALID), 32'd0);

        // Build acc=50, then CLR coincident with the pop of 5
        send_chk(4'h7, 8'd19, 1'b0, "b50");
        send_chk(4'h7, 8'd26, 1'b0, "b50");
        send_chk(4'h7, 8'd33, 1'b0, "b50");
        send_chk(4'h7, 8'd40, 1'b0, "b50");
        send_chk(4'h7, 8'd47, 1'b0, "b50");
        send_chk(4'h3, 8'd50, 1'b0, "b50");
        I = 4'h5; I_VALID = 1'b1; tick();
        I_VALID = 1'b0; CLR = 1'b1; tick(); CLR = 1'b0;
        chk("clrpop_o",   32'(O),       32'h05);
        chk("clrpop_ov",  32'(O_VALID), 32'd1);
        chk("clrpop_sat", 32'(SAT),     32'd0);
        send_chk(4'hF, 8'h04, 1'b0, "after_clrpop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/diff_acc4.md
# diff_acc4

Signed accumulator stage placed directly downstream of the 4-bit subtractor (`Sub4`). Each 4-bit difference word it accepts is read as two's complement, buffered in a small FIFO, and added into a saturating signed accumulator. Every updated total is presented on a valid/ready output port. The block turns the subtractor's combinational stream into a flow-controlled running sum, for example for net up/down counting from board switches.

## Interface
Parameters:
- `ACC_W`, default 8: accumulator and output width in bits. Legal range is 5..16.
- `DEPTH`, default 2: number of FIFO entries. Must be a power of two, 2..8.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESETN`  in  1  reset, asynchronous assert, active-low.
- `CLR`  in  1  synchronous clear of the accumulator and `SAT`.
- `I`  in  4  difference word from `Sub4.O`, two's complement (-8..7).
- `I_VALID`  in  1  `I` is valid this cycle.
- `I_READY`  out  1  FIFO can accept a word.
- `O`  out  ACC_W  running total after the most recent update, signed.
- `O_VALID`  out  1  `O` holds an unconsumed update.
- `O_READY`  in  1  downstream consumes `O` when this and `O_VALID` are both high.
- `SAT`  out  1  sticky flag: some update clipped since the last reset or `CLR`.

## Operation
- **Push.** A word is pushed when `I_VALID && I_READY`.
  - `I_READY = (fifo_count < DEPTH)`, decoded from registered count only.
  - A full FIFO deasserts `I_READY` even in a cycle where a pop occurs. There is no full-bypass path.
- **Pop.** A word is popped when `fifo_count != 0 && (!O_VALID || O_READY)`.
  - Only one pop per cycle.
  - FIFO order is strict: first in, first out.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
- **Update on pop.**
  - Compute `sum = base + sext(entry)` at ACC_W+1 bits.
  - `base` is `acc`, or 0 if `CLR` is high in the same cycle.
  - `acc` is clipped to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - `O <= acc` (the new, clipped value) and `O_VALID <= 1`.
  - If clipping occurred, `SAT <= 1`.
- **Output consumed, no pop.** If `O_VALID && O_READY` and no pop occurs, `O_VALID <= 0` and `O` holds its value.
- **`CLR` without a pop.**
  - Sets `acc <= 0` and `SAT <= 0`.
  - Does not touch `O`, `O_VALID` or the FIFO contents.
- **`CLR` with a clipping pop.** `SAT` ends the cycle at 1: the set wins over the clear.
- **Output stall.** While `O_VALID && !O_READY`:
  - `O` and `O_VALID` are stable.
  - No pop occurs, and the FIFO fills.
- **Reset.** `RESETN` low at any time, including mid-stream, immediately forces:
  - `acc=0`, `O=0`, `O_VALID=0`, `SAT=0`;
  - FIFO empty, so `I_READY=1`.
  - Buffered words are discarded.

## Timing
- **Latency.** A word accepted at edge k with the FIFO empty and `O` free is popped during cycle k+1. `O`/`O_VALID` show the result after edge k+1, i.e. one cycle of latency.
- **Throughput.** With `O_READY` held high, one update per cycle is sustained. `I_READY` stays 1 as long as input rate ≤ 1 per cycle.
- **Stall recovery.** `O_READY` rising with the FIFO full causes a pop in that cycle; `I_READY` rises after the next edge.
- **Combinational paths.**
  - `I_READY` depends only on registers.
  - There is no combinational path from `I_VALID` or `O_READY` to any output.
- **Reset release.** Deassertion of `RESETN` is synchronized externally. The first push is allowed on the first edge after release.

## Test plan
- **Reset.** Assert `RESETN` low mid-stream with 2 words buffered -> `O=0`, `O_VALID=0`, `SAT=0`, `I_READY=1`. A subsequent input 3 yields `O=3`.
- **Basic sequence.** With `O_READY=1`, stream `I` = 0x3, 0xE, 0x8, 0x7 -> `O` = 3, 1, -7 (0xF9), 0 on consecutive cycles, 1 cycle after each accept.
- **Positive saturation.** 20 words of 0x7 -> `O` climbs to 127 (0x7F) and holds. `SAT` rises on the update that would give 133.
- **Negative saturation, then `CLR`.** Feed words of 0x8 down to -128; `SAT=1`. Pulse `CLR` with no pop -> `SAT=0`, next input 0x2 gives `O=2`.
- **Backpressure.** Hold `O_READY=0` while offering 4 words -> first result held, 2 words buffered, `I_READY=0` (DEPTH=2). Releasing `O_READY` drains the words in order, no loss or duplication.
- **`CLR` coincident with pop.** `acc`=50, `CLR` high in the same cycle 0x5 is popped -> `O=5`, `SAT=0`.
